instr_dcd_burst: RTL

Multi-byte, burst-capable successor to the single-byte SPI instruction decoder. It sits between the SPI byte deserializer and the PWM register file. It turns a command byte followed by data bytes into register-bus read/write strobes on words of `DATA_BYTES` bytes. Optional address auto-increment lets one SPI frame access consecutive registers, and a frame-abort input resynchronises the decoder when chip-select drops.

---
 rtl/instr_dcd_burst.sv | 97 +++++++++
 1 files changed

// File: rtl/instr_dcd_burst.sv
// instr_dcd_burst: SPI command/data byte decoder driving register-bus read/write strobes with optional address auto-increment.
module instr_dcd_burst #(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_rst,
    input  logic                    byte_sync,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    read,
    output logic                    write,
    output logic [ADDR_W-1:0]       addr,
    input  logic [8*DATA_BYTES-1:0] data_read,
    output logic [8*DATA_BYTES-1:0] data_write
);
    localparam int DW = 8*DATA_BYTES;
    typedef enum logic [1:0] {CMD, WDATA, RDATA} state_t;
    state_t state, state_nxt;
    logic [1:0] cnt;
    logic burst, rd_pend, read_nxt, write_nxt, last;
    logic [DW-1:0] wbuf, rbuf, wnext;
    assign last = cnt == 2'(DATA_BYTES-1);
    assign wnext = (wbuf << 8) | DW'(data_in);
    assign data_out = rbuf[DW-1:DW-8];
    always_comb begin
        state_nxt = state;
        read_nxt = frame_rst ? 1'b0 : rd_pend;
        write_nxt = 1'b0;
        if (!frame_rst && byte_sync) begin
            case (state)
                CMD: begin
                    state_nxt = data_in[7] ? WDATA : RDATA;
                    read_nxt = !data_in[7];
                end
                WDATA: begin
                    write_nxt = last;
                    state_nxt = (last && !burst) ? CMD : WDATA;
                end
                RDATA: state_nxt = (last && !burst) ? CMD : RDATA;
                default: state_nxt = CMD;
            endcase
        end else if (frame_rst) begin
            state_nxt = CMD;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CMD;
            read <= 1'b0;
            write <= 1'b0;
            rd_pend <= 1'b0;
            burst <= 1'b0;
            cnt <= '0;
            addr <= '0;
            wbuf <= '0;
            rbuf <= '0;
            data_write <= '0;
        end else begin
            state <= state_nxt;
            read <= read_nxt;
            write <= write_nxt;
            rd_pend <= 1'b0;
            if (frame_rst) begin
                cnt <= '0;
                rbuf <= '0;
            end else begin
                if (write && burst) addr <= addr + 1'b1;
                if (read) rbuf <= data_read;
                if (byte_sync) begin
                    case (state)
                        CMD: begin
                            burst <= data_in[6];
                            addr <= data_in[ADDR_W-1:0];
                            cnt <= '0;
                        end
                        WDATA: begin
                            wbuf <= wnext;
                            cnt <= last ? 2'd0 : cnt + 2'd1;
                            if (last) data_write <= wnext;
                        end
                        RDATA: begin
                            cnt <= last ? 2'd0 : cnt + 2'd1;
                            rbuf <= (last && !burst) ? '0 : rbuf << 8;
                            if (last && burst) begin
                                addr <= addr + 1'b1;
                                rd_pend <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
